popcnt_decoder: RTL

POPCNT_DECODER -- requirements
Module: popcnt_decoder

---
 rtl/popcnt_decoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/popcnt_decoder.sv
// Buffers 2-bit ones-count words in a small FIFO and replays each one as a
// three-beat serial thermometer code (a,b,c) over a valid/ready output.
module popcnt_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_cnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bit,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, BIT0, BIT1, BIT2} state_t;

  state_t         state;
  logic [1:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [2:0]     shreg;
  logic           push;
  logic           pop;
  logic           beat;

  // Thermometer code, MSB emitted first: 0->000, 1->100, 2->110, 3->111.
  function automatic logic [2:0] thermo(input logic [1:0] c);
    return {c != 2'd0, c[1], c == 2'd3};
  endfunction

  // Outputs are decoded straight from registered state; the reset gate keeps
  // them quiet during the cycle reset is first asserted.
  assign in_ready  = !rst && (level < LW'(DEPTH));
  assign out_valid = !rst && (state != IDLE);
  assign out_bit   = !rst && shreg[2];
  assign out_last  = !rst && (state == BIT2);

  assign beat = out_valid && out_ready;
  assign push = in_valid && in_ready;
  assign pop  = (level != '0) && ((state == IDLE) || ((state == BIT2) && beat));

  // NOTE: the storage array carries no reset; level and the pointers alone
  // define which entries are live, so resetting the data would only add cost.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cnt;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      shreg  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= thermo(mem[rd_ptr]);
            state <= BIT0;
          end
        end
        BIT0: begin
          if (beat) begin
            shreg <= shreg << 1;
            state <= BIT1;
          end
        end
        BIT1: begin
          if (beat) begin
            shreg <= shreg << 1;
            state <= BIT2;
          end
        end
        BIT2: begin
          // Chain straight into the next word when one is queued.
          if (beat) begin
            if (pop) begin
              shreg <= thermo(mem[rd_ptr]);
              state <= BIT0;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
